// File: rtl/sys_clk_reset_ctrl.sv
// sys_clk_reset_ctrl: single-clock clock-enable generator and CPU reset sequencer.
// Channel 0 drives the CPU and supports turbo (half divisor) and pause. The other
// channels run freely from reset_n. The CPU reset is held until RST_HOLD channel-0
// strobes have elapsed with no reset request pending.
module sys_clk_reset_ctrl #(
    parameter int                      NUM_CE      = 3,
    parameter int                      DIV_W       = 12,
    parameter logic [NUM_CE*DIV_W-1:0] DIVS        = {12'd2048, 12'd2, 12'd8},
    parameter int                      RST_HOLD    = 255,
    parameter int                      SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              arm_reset,
    input  logic              osd_reset,
    input  logic              download,
    input  logic              turbo,
    input  logic              pause,
    output logic [NUM_CE-1:0] ce,
    output logic              cpu_reset_n,
    output logic              rom_loaded,
    output logic              reset_done
);

    // A divisor field of zero behaves as a divide-by-one channel.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] raw);
        return (raw == '0) ? DIV_W'(1) : raw;
    endfunction

    // Turbo period is half the normal one, never below one cycle.
    function automatic logic [DIV_W-1:0] half_div(input logic [DIV_W-1:0] full);
        return clamp_div(full >> 1);
    endfunction

    localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV0_FULL  = clamp_div(DIVS[DIV_W-1:0]);
    localparam logic [DIV_W-1:0] DIV0_TURBO = half_div(DIV0_FULL);
    localparam logic [15:0]      HOLD_TGT   = 16'(RST_HOLD);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_HOLD,
        ST_RUN
    } rst_state_e;

    // Synchroniser bits: 0 pll_locked, 1 arm_reset, 2 osd_reset, 3 download.
    logic [3:0]       sync_q [SYNC_STAGES];
    logic             pll_s;
    logic             arm_s;
    logic             osd_s;
    logic             dl_s;
    logic             req;

    logic             adv0;
    logic [DIV_W-1:0] cnt0_q;
    logic [DIV_W-1:0] cnt0_d;
    logic [DIV_W-1:0] div0_q;
    logic [DIV_W-1:0] div0_d;
    logic             ce0_q;
    logic             ce0_d;

    rst_state_e       state_q;
    logic [15:0]      hold_q;
    logic             cpu_reset_n_q;
    logic             reset_done_q;

    logic             dl_prev_q;
    logic             rom_loaded_q;

    logic [NUM_CE-1:0] ce_w;

    // Shift the asynchronous request inputs through the synchroniser chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= {download, osd_reset, arm_reset, pll_locked};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign pll_s = sync_q[SYNC_STAGES-1][0];
    assign arm_s = sync_q[SYNC_STAGES-1][1];
    assign osd_s = sync_q[SYNC_STAGES-1][2];
    assign dl_s  = sync_q[SYNC_STAGES-1][3];

    // Any synchronised source pending holds the CPU in reset.
    assign req = !pll_s || arm_s || osd_s || dl_s;

    // Channel 0 next state: pause freezes it only once the CPU is running; the
    // period length is re-chosen from turbo only at the wrap.
    always_comb begin
        adv0   = !(pause && cpu_reset_n_q);
        cnt0_d = cnt0_q;
        div0_d = div0_q;
        ce0_d  = 1'b0;
        if (adv0) begin
            if (cnt0_q == div0_q - ONE) begin
                cnt0_d = '0;
                div0_d = turbo ? DIV0_TURBO : DIV0_FULL;
            end else begin
                cnt0_d = cnt0_q + ONE;
            end
            ce0_d = (cnt0_d == div0_d - ONE);
        end
    end

    // Channel 0 counter, active period length and strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            div0_q <= DIV0_FULL;
            ce0_q  <= 1'b0;
        end else begin
            cnt0_q <= cnt0_d;
            div0_q <= div0_d;
            ce0_q  <= ce0_d;
        end
    end

    assign ce_w[0] = ce0_q;

    for (genvar i = 1; i < NUM_CE; i++) begin : g_ch
        localparam logic [DIV_W-1:0] DIV_I = clamp_div(DIVS[i*DIV_W +: DIV_W]);

        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_d;
        logic             ce_q;

        // Free-running count that wraps after DIV_I cycles.
        always_comb begin
            cnt_d = (cnt_q == DIV_I - ONE) ? '0 : cnt_q + ONE;
        end

        // Strobe is aligned with the terminal count of the channel.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                ce_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ce_q  <= (cnt_d == DIV_I - ONE);
            end
        end

        assign ce_w[i] = ce_q;
    end

    // Reset sequencer: a request clears the hold, then RST_HOLD channel-0
    // strobes must pass before the CPU is released; the count then saturates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_REQ;
            hold_q        <= '0;
            cpu_reset_n_q <= 1'b0;
            reset_done_q  <= 1'b0;
        end else begin
            reset_done_q <= 1'b0;
            if (req) begin
                state_q       <= ST_REQ;
                hold_q        <= '0;
                cpu_reset_n_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_REQ, ST_HOLD: begin
                        state_q <= ST_HOLD;
                        if (ce0_q) begin
                            hold_q <= hold_q + 16'd1;
                            if (hold_q + 16'd1 == HOLD_TGT) begin
                                state_q       <= ST_RUN;
                                cpu_reset_n_q <= 1'b1;
                                reset_done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        cpu_reset_n_q <= 1'b1;
                    end
                    default: begin
                        state_q       <= ST_REQ;
                        hold_q        <= '0;
                        cpu_reset_n_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky download-complete flag, set one cycle after the synchronised fall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev_q    <= 1'b0;
            rom_loaded_q <= 1'b0;
        end else begin
            dl_prev_q <= dl_s;
            if (dl_prev_q && !dl_s) begin
                rom_loaded_q <= 1'b1;
            end
        end
    end

    assign ce          = ce_w;
    assign cpu_reset_n = cpu_reset_n_q;
    assign rom_loaded  = rom_loaded_q;
    assign reset_done  = reset_done_q;

endmodule

// File: tb/tb_sys_clk_reset_ctrl.sv
// Scoreboard bench for sys_clk_reset_ctrl: two instances (default parameters and a
// four-channel variant with a zero divisor field) share the same stimulus. A
// reference model pushes the expected outputs after every rising edge; a monitor
// pops and compares them on the falling edge.
module tb_sys_clk_reset_ctrl;

    localparam int DW = 12;

    localparam int                    A_NCE  = 3;
    localparam logic [A_NCE*DW-1:0]   A_DIVS = {12'd2048, 12'd2, 12'd8};
    localparam int                    A_HOLD = 255;
    localparam int                    A_SS   = 2;

    localparam int                    B_NCE  = 4;
    localparam logic [B_NCE*DW-1:0]   B_DIVS = {12'd5, 12'd0, 12'd3, 12'd6};
    localparam int                    B_HOLD = 4;
    localparam int                    B_SS   = 3;

    logic clock      = 1'b0;
    logic reset_n    = 1'b0;
    logic pll_locked = 1'b1;
    logic arm_reset  = 1'b0;
    logic osd_reset  = 1'b0;
    logic download   = 1'b0;
    logic turbo      = 1'b0;
    logic pause      = 1'b0;

    logic [A_NCE-1:0] ce_a;
    logic             cpu_a, rom_a, done_a;
    logic [B_NCE-1:0] ce_b;
    logic             cpu_b, rom_b, done_b;

    always #5 clock = ~clock;

    sys_clk_reset_ctrl #(
        .NUM_CE(A_NCE), .DIV_W(DW), .DIVS(A_DIVS), .RST_HOLD(A_HOLD), .SYNC_STAGES(A_SS)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked), .arm_reset(arm_reset),
        .osd_reset(osd_reset), .download(download), .turbo(turbo), .pause(pause),
        .ce(ce_a), .cpu_reset_n(cpu_a), .rom_loaded(rom_a), .reset_done(done_a)
    );

    sys_clk_reset_ctrl #(
        .NUM_CE(B_NCE), .DIV_W(DW), .DIVS(B_DIVS), .RST_HOLD(B_HOLD), .SYNC_STAGES(B_SS)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked), .arm_reset(arm_reset),
        .osd_reset(osd_reset), .download(download), .turbo(turbo), .pause(pause),
        .ce(ce_b), .cpu_reset_n(cpu_b), .rom_loaded(rom_b), .reset_done(done_b)
    );

    typedef struct packed {
        logic [3:0] ce;
        logic       cpu;
        logic       rom;
        logic       done;
    } exp_t;

    // k: rising edges since reset_n released; t0: cycles spent in the current CPU
    // period; per0: length of that period; hold: CPU strobes counted since the
    // last request.
    typedef struct packed {
        int k;
        int t0;
        int per0;
        int hold;
        bit cpu;
        bit done;
        bit rom;
        bit ce0;
    } model_t;

    // Input values sampled at each rising edge since reset_n released.
    bit h_pll[$];
    bit h_arm[$];
    bit h_osd[$];
    bit h_dl[$];

    exp_t   qa[$];
    exp_t   qb[$];
    model_t ma;
    model_t mb;

    int vectors     = 0;
    int miscompares = 0;

    function automatic int clamp1(int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Request as seen through the synchroniser; before any sample, pll is seen low.
    function automatic bit req_seen(int j);
        if (j < 1) return 1'b1;
        return !h_pll[j-1] || h_arm[j-1] || h_osd[j-1] || h_dl[j-1];
    endfunction

    function automatic bit dl_seen(int j);
        if (j < 1) return 1'b0;
        return h_dl[j-1];
    endfunction

    function automatic model_t model_reset(int full0);
        model_t m;
        m      = '0;
        m.per0 = full0;
        return m;
    endfunction

    // Advance the reference by one rising edge; ss is the synchroniser depth.
    function automatic model_t step(model_t m, int ss, int full0, int hold_tgt, bit p, bit t);
        model_t n;
        int     half0;
        n      = m;
        half0  = clamp1(full0 / 2);
        n.k    = m.k + 1;
        n.done = 1'b0;
        if (req_seen(n.k - ss)) begin
            n.hold = 0;
            n.cpu  = 1'b0;
        end else if (!m.cpu && m.ce0) begin
            n.hold = m.hold + 1;
            if (n.hold == hold_tgt) begin
                n.cpu  = 1'b1;
                n.done = 1'b1;
            end
        end
        if (dl_seen(n.k - ss - 1) && !dl_seen(n.k - ss)) n.rom = 1'b1;
        n.ce0 = 1'b0;
        if (!(p && m.cpu)) begin
            if (m.t0 + 1 >= m.per0) begin
                n.t0   = 0;
                n.per0 = t ? half0 : full0;
            end else begin
                n.t0 = m.t0 + 1;
            end
            n.ce0 = (n.t0 + 1 == n.per0);
        end
        return n;
    endfunction

    // Free-running channels pulse on every edge k where k is one short of a multiple of D.
    function automatic exp_t expect_of(model_t m, int nce, int r1, int r2, int r3);
        exp_t e;
        int   d;
        e      = '0;
        e.ce[0] = m.ce0;
        e.cpu  = m.cpu;
        e.rom  = m.rom;
        e.done = m.done;
        for (int i = 1; i < nce; i++) begin
            d = clamp1((i == 1) ? r1 : (i == 2) ? r2 : r3);
            e.ce[i] = (m.k > 0) && ((m.k % d) == d - 1);
        end
        return e;
    endfunction

    // Reference model: one expectation per rising edge for each instance.
    always @(posedge clock) begin
        if (!reset_n) begin
            h_pll.delete();
            h_arm.delete();
            h_osd.delete();
            h_dl.delete();
            ma = model_reset(clamp1(8));
            mb = model_reset(clamp1(6));
        end else begin
            h_pll.push_back(pll_locked);
            h_arm.push_back(arm_reset);
            h_osd.push_back(osd_reset);
            h_dl.push_back(download);
            ma = step(ma, A_SS, clamp1(8), A_HOLD, pause, turbo);
            mb = step(mb, B_SS, clamp1(6), B_HOLD, pause, turbo);
        end
        qa.push_back(expect_of(ma, A_NCE, 2, 2048, 0));
        qb.push_back(expect_of(mb, B_NCE, 3, 0, 5));
    end

    exp_t ea, eb, ga, gb;

    // Monitor: compare DUT outputs against the queued expectations.
    always @(negedge clock) begin
        if (qa.size() != 0) begin
            ea = qa.pop_front();
            ga = {4'(ce_a), cpu_a, rom_a, done_a};
            vectors++;
            if (ga !== ea) begin
                miscompares++;
                $display("FAIL dut_a t=%0t got ce=%b cpu_rst_n=%b rom=%b done=%b, want ce=%b cpu_rst_n=%b rom=%b done=%b",
                         $time, ga.ce, ga.cpu, ga.rom, ga.done, ea.ce, ea.cpu, ea.rom, ea.done);
            end
        end
        if (qb.size() != 0) begin
            eb = qb.pop_front();
            gb = {ce_b, cpu_b, rom_b, done_b};
            vectors++;
            if (gb !== eb) begin
                miscompares++;
                $display("FAIL dut_b t=%0t got ce=%b cpu_rst_n=%b rom=%b done=%b, want ce=%b cpu_rst_n=%b rom=%b done=%b",
                         $time, gb.ce, gb.cpu, gb.rom, gb.done, eb.ce, eb.cpu, eb.rom, eb.done);
            end
        end
    end

    // Inputs change just after a falling edge, clear of both sampling points.
    task automatic cyc(int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        ma = model_reset(8);
        mb = model_reset(6);

        // Power-up with PLL locked, then a full reset release.
        cyc(5);
        reset_n = 1'b1;
        cyc(2300);

        // Turbo switched on mid-period, then back off.
        cyc(3);
        turbo = 1'b1;
        cyc(60);
        turbo = 1'b0;
        cyc(60);

        // Pause for 20 cycles while the CPU runs; turbo change coinciding with pause.
        pause = 1'b1;
        cyc(20);
        pause = 1'b0;
        cyc(37);
        pause = 1'b1;
        turbo = 1'b1;
        cyc(13);
        pause = 1'b0;
        cyc(50);
        turbo = 1'b0;
        cyc(30);

        // Single-cycle arm_reset, then another one about 100 strobes into the hold.
        arm_reset = 1'b1;
        cyc(1);
        arm_reset = 1'b0;
        cyc(2 + 8 * 100);
        arm_reset = 1'b1;
        cyc(1);
        arm_reset = 1'b0;
        cyc(2300);

        // Download cycle, then an OSD reset that must leave rom_loaded set.
        download = 1'b1;
        cyc(30);
        download = 1'b0;
        cyc(100);
        osd_reset = 1'b1;
        cyc(2);
        osd_reset = 1'b0;
        cyc(2300);

        // Random requests, download toggles, turbo and pause.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) turbo = ~turbo;
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            arm_reset  = ($urandom_range(0, 299) == 0);
            osd_reset  = ($urandom_range(0, 299) == 0);
            pll_locked = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 199) == 0) download = ~download;
            cyc(1);
        end
        arm_reset  = 1'b0;
        osd_reset  = 1'b0;
        pll_locked = 1'b1;
        download   = 1'b0;

        // Quiet requests so the CPU is released, then random turbo/pause only.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) turbo = ~turbo;
            if ($urandom_range(0, 11) == 0) pause = ~pause;
            cyc(1);
        end
        pause = 1'b0;
        turbo = 1'b0;
        cyc(20);

        // Asynchronous reset mid-run clears rom_loaded and restarts everything.
        reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(2300);

        cyc(2);
        if (vectors < 1000) begin
            miscompares++;
            $display("FAIL vector_count got %0d, want at least 1000", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
